// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte with
// odd parity and checks the device acknowledge, flagging timeouts and missing acks.
module ps2_command_tx #(
    parameter int CLK_HOLD      = 5000,
    parameter int START_TIMEOUT = 750000,
    parameter int BIT_TIMEOUT   = 100000,
    parameter int CNT_W         = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       send_command,
    input  logic [7:0] the_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, START, WAIT_FIRST, SEND, WAIT_ACK, WAIT_IDLE, DONE, ERROR
    } state_t;

    // INHIBIT lasts one cycle less than the hold so that, with START, the clock is low CLK_HOLD cycles.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_HOLD - 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic             dat_low, dat_low_n;
    logic             load;
    logic [9:0]       frame;
    logic             clk_p0, clk_p1, clk_p2, fall_p2;
    logic             dat_p0, dat_p1;

    // Stage p0/p1: pad synchronisers; p2: registered falling-edge detect.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_p0  <= 1'b1;
            clk_p1  <= 1'b1;
            clk_p2  <= 1'b1;
            fall_p2 <= 1'b0;
            dat_p0  <= 1'b1;
            dat_p1  <= 1'b1;
        end else begin
            clk_p0  <= ps2_clk_in;
            clk_p1  <= clk_p0;
            clk_p2  <= clk_p1;
            fall_p2 <= clk_p2 & ~clk_p1;
            dat_p0  <= ps2_dat_in;
            dat_p1  <= dat_p0;
        end
    end

    // Frame is {stop, parity, data}, shifted out LSB first.
    always_ff @(posedge clock) begin
        if (load) frame <= {1'b1, odd_parity(the_command), the_command};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            dat_low <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            dat_low <= dat_low_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = sat_inc(timer);
        bit_idx_n = bit_idx;
        dat_low_n = dat_low;
        load      = 1'b0;
        case (state)
            IDLE: begin
                timer_n   = '0;
                bit_idx_n = '0;
                if (send_command) begin
                    load    = 1'b1;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer >= HOLD_LAST) begin
                    state_n   = START;
                    dat_low_n = 1'b1;
                end
            end
            START: begin
                state_n = WAIT_FIRST;
                timer_n = '0;
            end
            WAIT_FIRST: begin
                if (fall_p2) begin
                    dat_low_n = ~frame[0];
                    bit_idx_n = 4'd1;
                    timer_n   = '0;
                    state_n   = SEND;
                end else if (timer >= START_LAST) begin
                    state_n = ERROR;
                end
            end
            SEND: begin
                if (fall_p2) begin
                    dat_low_n = ~frame[bit_idx];
                    timer_n   = '0;
                    if (bit_idx == 4'd9) state_n = WAIT_ACK;
                    else bit_idx_n = bit_idx + 4'd1;
                end else if (timer >= BIT_LAST) begin
                    state_n = ERROR;
                end
            end
            WAIT_ACK: begin
                dat_low_n = 1'b0;
                if (fall_p2) begin
                    timer_n = '0;
                    state_n = dat_p1 ? ERROR : WAIT_IDLE;
                end else if (timer >= BIT_LAST) begin
                    state_n = ERROR;
                end
            end
            WAIT_IDLE: begin
                if (clk_p1 && dat_p1) state_n = DONE;
                else if (timer >= BIT_LAST) state_n = ERROR;
            end
            DONE:    state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // The data line is only ever held by the host while a frame is in flight.
        if (state_n == ERROR || state_n == DONE || state_n == IDLE) dat_low_n = 1'b0;
    end

    assign ps2_clk_drive_low             = (state == INHIBIT) || (state == START);
    assign ps2_dat_drive_low             = dat_low;
    assign busy                          = (state != IDLE);
    assign command_was_sent              = (state == DONE);
    assign error_communication_timed_out = (state == ERROR);

endmodule
